// File: rtl/mycpu_pkg.sv
// Shared definitions for the MEM stage and its helpers.
//   DATA_W          : data bus width assumed by the extraction logic
//   LD_SIZE_B/H/W   : es_ld_size encodings (byte, half, word)
//   MS_ST_*         : per-instruction response state held in MEM
//   ld_misaligned() : alignment test used when MS_MISALIGN_CHECK_EN is defined
package mycpu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    LD_SIZE_B = 2'b00,
    LD_SIZE_H = 2'b01,
    LD_SIZE_W = 2'b10
  } ld_size_e;

  typedef enum logic [1:0] {
    MS_ST_NOREQ = 2'b00,
    MS_ST_WAIT  = 2'b01,
    MS_ST_HELD  = 2'b10
  } ms_st_e;

  function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    ld_misaligned = ((size == LD_SIZE_H) && addr_lo[0]) ||
                    ((size == LD_SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// EX->MEM handshake plus the data-response channel of the handshake bus.
//   master : EX / memory side, drives instruction fields and responses,
//            observes ms_allowin
//   slave  : MEM stage, consumes instruction fields and responses,
//            drives ms_allowin
interface mem_stage_hs_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
);
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [PC_W-1:0]   es_pc;
  logic [DATA_W-1:0] es_alu_result;
  logic [4:0]        es_dest;
  logic              es_gr_we;
  logic              es_ld_en;
  logic [1:0]        es_ld_size;
  logic              es_ld_sign;
  logic              es_req_sent;
  logic              es_req_pending;
  logic              data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we,
           es_ld_en, es_ld_size, es_ld_sign, es_req_sent, es_req_pending,
           data_ok, data_rdata,
    input  ms_allowin
  );

  modport slave (
    input  es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we,
           es_ld_en, es_ld_size, es_ld_sign, es_req_sent, es_req_pending,
           data_ok, data_rdata,
    output ms_allowin
  );
endinterface

// File: rtl/mem_stage_hs_load_extract.sv
// load_extract: combinational byte/half/word selection and extension.
//   raw     : 32-bit response word (buffered or live)
//   addr_lo : load address bits [1:0]
//   size    : LD_SIZE_B / LD_SIZE_H / LD_SIZE_W
//   sign    : 1 = sign-extend, 0 = zero-extend
//   result  : extended 32-bit value
// Half uses addr_lo[1] only; word ignores addr_lo.
module load_extract
  import mycpu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    result = raw;
    case (size)
      LD_SIZE_B: result = {{24{sign & byte_sel[7]}}, byte_sel};
      LD_SIZE_H: result = {{16{sign & half_sel[15]}}, half_sel};
      default:   result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage for a req/addr_ok/data_ok data bus.
// Waits for the load response, extracts/extends it, buffers it while WB
// stalls, cancels in-flight responses on flush, and drives ID forwarding.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush             : kill stage contents, cancel outstanding responses
//   ws_allowin        : WB can accept
//   bus (slave)       : EX->MEM fields, ms_allowin, data_ok/data_rdata
//   ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result : to WB
//   ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_stall       : to ID
//   ms_ale            : misaligned load flag (only with MS_MISALIGN_CHECK_EN)
// Build option: define MS_MISALIGN_CHECK_EN to add misaligned-load detection.
module mem_stage_hs
  import mycpu_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ws_allowin,
  mem_stage_hs_if.slave     bus,
  output logic              ms_to_ws_valid,
  output logic [PC_W-1:0]   ms_pc,
  output logic [4:0]        ms_dest,
  output logic              ms_gr_we,
  output logic [DATA_W-1:0] ms_final_result,
  output logic              ms_fwd_valid,
  output logic [4:0]        ms_fwd_dest,
  output logic [DATA_W-1:0] ms_fwd_data,
  output logic              ms_fwd_stall
`ifdef MS_MISALIGN_CHECK_EN
  ,
  output logic              ms_ale
`endif
);

  if (DATA_W != 32) begin : g_width_check
    $error("mem_stage_hs: DATA_W must be 32");
  end

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic              ms_valid;
  ms_st_e            ms_st, ms_st_nxt;
  logic [PC_W-1:0]   pc_r;
  logic [DATA_W-1:0] alu_r;
  logic [4:0]        dest_r;
  logic              gr_we_r;
  logic              ld_en_r;
  ld_size_e          ld_size_r;
  logic              ld_sign_r;
  logic [DATA_W-1:0] buf_r;
  logic              buf_load;
  logic [CNT_W-1:0]  cancel_cnt;
  logic [CNT_W+1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_nxt;

  logic   cancel_hit;
  logic   resp_live;
  logic   st_wait;
  logic   ms_ready_go;
  logic   ms_allowin;
  logic   accept;
  logic   es_mis;
  logic   ale;
  ms_st_e ent_st;
  logic [DATA_W-1:0] raw_word;
  logic [31:0]       ext_result;

  // Response routing: a data_ok is either owed to a cancelled request
  // (cancel_cnt > 0) or belongs to the load currently in MEM.
  assign cancel_hit  = bus.data_ok && (cancel_cnt != '0);
  assign resp_live   = bus.data_ok && (cancel_cnt == '0);
  assign st_wait     = (ms_st == MS_ST_WAIT);
  assign ms_ready_go = (ms_st == MS_ST_NOREQ) || (ms_st == MS_ST_HELD) ||
                       (st_wait && resp_live);
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign accept      = bus.es_to_ms_valid && ms_allowin;
  assign bus.ms_allowin = ms_allowin;

`ifdef MS_MISALIGN_CHECK_EN
  assign es_mis = bus.es_ld_en && ld_misaligned(bus.es_ld_size, bus.es_alu_result[1:0]);
  assign ale    = ms_valid && ld_en_r && ld_misaligned(ld_size_r, alu_r[1:0]);
  assign ms_ale = ale;
`else
  assign es_mis = 1'b0;
  assign ale    = 1'b0;
`endif

  assign ent_st = (bus.es_ld_en && bus.es_req_sent && !es_mis) ? MS_ST_WAIT : MS_ST_NOREQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_st <= MS_ST_NOREQ;
    end else begin
      ms_st <= ms_st_nxt;
    end
  end

  // The instruction leaves exactly when ms_allowin is high, so the pass-through
  // case needs no state of its own; only a live response that WB cannot take
  // this cycle moves the instruction to HELD.
  always_comb begin
    ms_st_nxt = ms_st;
    buf_load  = 1'b0;
    if (flush) begin
      ms_st_nxt = MS_ST_NOREQ;
    end else if (ms_allowin) begin
      ms_st_nxt = bus.es_to_ms_valid ? ent_st : MS_ST_NOREQ;
    end else if (ms_valid && st_wait && resp_live) begin
      ms_st_nxt = MS_ST_HELD;
      buf_load  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= bus.es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gr_we_r <= 1'b0;
      ld_en_r <= 1'b0;
    end else if (accept && !flush) begin
      pc_r      <= bus.es_pc;
      alu_r     <= bus.es_alu_result;
      dest_r    <= bus.es_dest;
      gr_we_r   <= bus.es_gr_we;
      ld_en_r   <= bus.es_ld_en;
      ld_size_r <= ld_size_e'(bus.es_ld_size);
      ld_sign_r <= bus.es_ld_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_r <= bus.data_rdata;
    end
  end

  // On flush the MEM load stays owed unless its own response lands this
  // cycle; a response consumed by an older cancel does not settle it.
  always_comb begin
    cnt_sum = {2'b00, cancel_cnt};
    if (flush && ms_valid && st_wait && !resp_live) begin
      cnt_sum = cnt_sum + (CNT_W+2)'(1);
    end
    if (flush && bus.es_req_pending) begin
      cnt_sum = cnt_sum + (CNT_W+2)'(1);
    end
    if (cancel_hit) begin
      cnt_sum = cnt_sum - (CNT_W+2)'(1);
    end
    if (cnt_sum > (CNT_W+2)'(MAX_INFLIGHT)) begin
      cnt_nxt = CNT_W'(MAX_INFLIGHT);
    end else begin
      cnt_nxt = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt <= '0;
    end else begin
      cancel_cnt <= cnt_nxt;
    end
  end

  a_cancel_no_overflow: assert property (
    @(posedge clk) disable iff (reset) cnt_sum <= (CNT_W+2)'(MAX_INFLIGHT)
  );

  assign raw_word = (ms_st == MS_ST_HELD) ? buf_r : bus.data_rdata;

  load_extract u_load_extract (
    .raw     (raw_word),
    .addr_lo (alu_r[1:0]),
    .size    (ld_size_r),
    .sign    (ld_sign_r),
    .result  (ext_result)
  );

  assign ms_to_ws_valid  = ms_valid && ms_ready_go;
  assign ms_pc           = pc_r;
  assign ms_dest         = dest_r;
  assign ms_gr_we        = gr_we_r && !ale;
  assign ms_final_result = ld_en_r ? ext_result : alu_r;
  assign ms_fwd_valid    = ms_valid && ms_gr_we;
  assign ms_fwd_dest     = dest_r;
  assign ms_fwd_data     = ms_final_result;
  assign ms_fwd_stall    = ms_valid && ld_en_r && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Define MS_MISALIGN_CHECK_EN to exercise ms_ale.
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic [31:0] ms_final_result;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_stall;
`ifdef MS_MISALIGN_CHECK_EN
  logic        ms_ale;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.PC_W(32), .DATA_W(32)) bus ();

  mem_stage_hs #(.PC_W(32), .DATA_W(32), .MAX_INFLIGHT(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .ws_allowin      (ws_allowin),
    .bus             (bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_dest         (ms_dest),
    .ms_gr_we        (ms_gr_we),
    .ms_final_result (ms_final_result),
    .ms_fwd_valid    (ms_fwd_valid),
    .ms_fwd_dest     (ms_fwd_dest),
    .ms_fwd_data     (ms_fwd_data),
    .ms_fwd_stall    (ms_fwd_stall)
`ifdef MS_MISALIGN_CHECK_EN
    ,
    .ms_ale          (ms_ale)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic es_idle();
    bus.es_to_ms_valid = 1'b0;
    bus.es_pc          = '0;
    bus.es_alu_result  = '0;
    bus.es_dest        = '0;
    bus.es_gr_we       = 1'b0;
    bus.es_ld_en       = 1'b0;
    bus.es_ld_size     = 2'b00;
    bus.es_ld_sign     = 1'b0;
    bus.es_req_sent    = 1'b0;
    bus.es_req_pending = 1'b0;
  endtask

  task automatic es_load(input logic [31:0] pc, input logic [31:0] addr, input logic [4:0] dest,
                         input logic [1:0] size, input logic sign, input logic sent);
    bus.es_to_ms_valid = 1'b1;
    bus.es_pc          = pc;
    bus.es_alu_result  = addr;
    bus.es_dest        = dest;
    bus.es_gr_we       = 1'b1;
    bus.es_ld_en       = 1'b1;
    bus.es_ld_size     = size;
    bus.es_ld_sign     = sign;
    bus.es_req_sent    = sent;
  endtask

  task automatic resp(input logic ok, input logic [31:0] rdata);
    bus.data_ok    = ok;
    bus.data_rdata = rdata;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    ws_allowin = 1'b1;
    es_idle();
    resp(1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    sample();
    check_eq("rst_to_ws_valid", ms_to_ws_valid, 0);
    check_eq("rst_allowin", bus.ms_allowin, 1);
    check_eq("rst_fwd_valid", ms_fwd_valid, 0);
    check_eq("rst_fwd_stall", ms_fwd_stall, 0);

    // ALU op passes straight through
    tick();
    bus.es_to_ms_valid = 1'b1;
    bus.es_pc          = 32'h1C00_0000;
    bus.es_alu_result  = 32'h1234_5678;
    bus.es_dest        = 5'd5;
    bus.es_gr_we       = 1'b1;
    tick();
    es_idle();
    sample();
    check_eq("alu_valid", ms_to_ws_valid, 1);
    check_eq("alu_pc", ms_pc, 32'h1C00_0000);
    check_eq("alu_result", ms_final_result, 32'h1234_5678);
    check_eq("alu_gr_we", ms_gr_we, 1);
    check_eq("alu_fwd_valid", ms_fwd_valid, 1);
    check_eq("alu_fwd_dest", ms_fwd_dest, 5);
    check_eq("alu_fwd_data", ms_fwd_data, 32'h1234_5678);
    check_eq("alu_fwd_stall", ms_fwd_stall, 0);
    tick();
    sample();
    check_eq("alu_drained", ms_to_ws_valid, 0);

    // lb signed, addr[1:0]=3, response after 3 cycles
    tick();
    es_load(32'h1C00_0004, 32'h0000_1003, 5'd6, 2'b00, 1'b1, 1'b1);
    tick();
    es_idle();
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq($sformatf("lb_stall%0d", i), ms_fwd_stall, 1);
      check_eq($sformatf("lb_wait_valid%0d", i), ms_to_ws_valid, 0);
      tick();
    end
    resp(1'b1, 32'h80FF_00AA);
    sample();
    check_eq("lb_valid", ms_to_ws_valid, 1);
    check_eq("lb_result", ms_final_result, 32'hFFFF_FF80);
    check_eq("lb_stall_clear", ms_fwd_stall, 0);
    tick();
    resp(1'b0, 32'h0);

    // lhu upper half, WB stalled for 4 cycles -> buffered
    ws_allowin = 1'b0;
    es_load(32'h1C00_0008, 32'h0000_2002, 5'd7, 2'b01, 1'b0, 1'b1);
    tick();
    es_idle();
    resp(1'b1, 32'hBEEF_1234);
    sample();
    check_eq("lhu_live_result", ms_final_result, 32'h0000_BEEF);
    check_eq("lhu_live_allowin", bus.ms_allowin, 0);
    tick();
    resp(1'b0, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq($sformatf("lhu_held_result%0d", i), ms_final_result, 32'h0000_BEEF);
      check_eq($sformatf("lhu_held_allowin%0d", i), bus.ms_allowin, 0);
      check_eq($sformatf("lhu_held_valid%0d", i), ms_to_ws_valid, 1);
      tick();
    end
    ws_allowin = 1'b1;
    sample();
    check_eq("lhu_release_result", ms_final_result, 32'h0000_BEEF);
    check_eq("lhu_release_allowin", bus.ms_allowin, 1);
    tick();
    sample();
    check_eq("lhu_drained", ms_to_ws_valid, 0);

    // Flush with MEM waiting and a pending EX request -> two cancels
    tick();
    es_load(32'h1C00_0010, 32'h0000_3000, 5'd8, 2'b10, 1'b0, 1'b1);
    tick();
    es_idle();
    flush = 1'b1;
    bus.es_req_pending = 1'b1;
    tick();
    flush = 1'b0;
    bus.es_req_pending = 1'b0;
    sample();
    check_eq("flush_killed", ms_to_ws_valid, 0);
    tick();
    es_load(32'h1C00_0014, 32'h0000_4000, 5'd9, 2'b10, 1'b0, 1'b1);
    tick();
    es_idle();
    resp(1'b1, 32'h0000_DEAD);
    sample();
    check_eq("cancel1_dropped", ms_to_ws_valid, 0);
    check_eq("cancel1_stall", ms_fwd_stall, 1);
    tick();
    resp(1'b1, 32'h0000_BEEF);
    sample();
    check_eq("cancel2_dropped", ms_to_ws_valid, 0);
    tick();
    resp(1'b1, 32'hCAFE_F00D);
    sample();
    check_eq("post_cancel_valid", ms_to_ws_valid, 1);
    check_eq("post_cancel_result", ms_final_result, 32'hCAFE_F00D);
    tick();
    resp(1'b0, 32'h0);

    // Flush coinciding with a cancel-covered response: 1 -> 1
    es_load(32'h1C00_0020, 32'h0000_5000, 5'd10, 2'b10, 1'b0, 1'b1);
    tick();
    es_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    es_load(32'h1C00_0024, 32'h0000_5004, 5'd11, 2'b10, 1'b0, 1'b1);
    tick();
    es_idle();
    flush = 1'b1;
    resp(1'b1, 32'h7777_7777);
    tick();
    flush = 1'b0;
    resp(1'b0, 32'h0);

    // Stream: lh signed lane0, lbu lane1, lw; one cancel still owed
    es_load(32'h1C00_0030, 32'h0000_6000, 5'd12, 2'b01, 1'b1, 1'b1);
    tick();
    es_load(32'h1C00_0034, 32'h0000_6001, 5'd13, 2'b00, 1'b0, 1'b1);
    resp(1'b1, 32'h1111_1111);
    sample();
    check_eq("net_cancel_dropped", ms_to_ws_valid, 0);
    check_eq("net_cancel_allowin", bus.ms_allowin, 0);
    tick();
    resp(1'b1, 32'h1234_8001);
    sample();
    check_eq("stream_lh_valid", ms_to_ws_valid, 1);
    check_eq("stream_lh_result", ms_final_result, 32'hFFFF_8001);
    check_eq("stream_lh_allowin", bus.ms_allowin, 1);
    tick();
    es_load(32'h1C00_0038, 32'h0000_6008, 5'd14, 2'b10, 1'b0, 1'b1);
    resp(1'b1, 32'h0000_A500);
    sample();
    check_eq("stream_lbu_valid", ms_to_ws_valid, 1);
    check_eq("stream_lbu_result", ms_final_result, 32'h0000_00A5);
    tick();
    es_idle();
    resp(1'b1, 32'hA1B2_C3D4);
    sample();
    check_eq("stream_lw_valid", ms_to_ws_valid, 1);
    check_eq("stream_lw_result", ms_final_result, 32'hA1B2_C3D4);
    check_eq("stream_lw_pc", ms_pc, 32'h1C00_0038);
    tick();
    resp(1'b0, 32'h0);
    sample();
    check_eq("stream_drained", ms_to_ws_valid, 0);

`ifdef MS_MISALIGN_CHECK_EN
    // Misaligned lw: no response awaited, register write suppressed
    tick();
    es_load(32'h1C00_0040, 32'h0000_7002, 5'd15, 2'b10, 1'b0, 1'b0);
    tick();
    es_idle();
    sample();
    check_eq("ale_flag", ms_ale, 1);
    check_eq("ale_gr_we", ms_gr_we, 0);
    check_eq("ale_valid", ms_to_ws_valid, 1);
    check_eq("ale_stall", ms_fwd_stall, 0);
    check_eq("ale_fwd_valid", ms_fwd_valid, 0);
`else
    // lw with low address bits set: the full word is returned
    tick();
    es_load(32'h1C00_0040, 32'h0000_7003, 5'd15, 2'b10, 1'b0, 1'b1);
    tick();
    es_idle();
    resp(1'b1, 32'h0BAD_F00D);
    sample();
    check_eq("lw_unaligned_result", ms_final_result, 32'h0BAD_F00D);
    check_eq("lw_unaligned_gr_we", ms_gr_we, 1);
`endif
    tick();
    resp(1'b0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation MEM pipeline stage for a handshake data bus (req/addr_ok/data_ok) with variable response latency.
- Sits between EX and WB. Waits for the load response, extracts and extends the byte/half/word, and holds the result in a skid buffer when WB stalls.
- On a pipeline flush, discards responses still in flight.
- Drives the forwarding/interlock information consumed by ID.

Parameters:
- PC_W, 32, width of PC field
- DATA_W, 32, data bus width; fixed to 32 for extraction logic (elaboration error otherwise)
- MAX_INFLIGHT, 2, max responses that can be outstanding and cancelled (EX + MEM); sizes cancel counter to $clog2(MAX_INFLIGHT+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill stage contents and cancel in-flight responses
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EX presents instruction
- es_pc  in  PC_W  instruction PC
- es_alu_result  in  DATA_W  ALU result / load address
- es_dest  in  5  destination register
- es_gr_we  in  1  register write enable
- es_ld_en  in  1  instruction is a load
- es_ld_size  in  2  00 byte, 01 half, 10 word
- es_ld_sign  in  1  sign-extend
- es_req_sent  in  1  EX got addr_ok for this load (response expected)
- es_req_pending  in  1  EX holds an accepted request not yet passed to MEM
- data_ok  in  1  response valid
- data_rdata  in  DATA_W  response data
- ms_to_ws_valid  out  1  result valid to WB
- ms_pc  out  PC_W
- ms_dest  out  5
- ms_gr_we  out  1
- ms_final_result  out  DATA_W
- ms_fwd_valid  out  1  ms_valid && ms_gr_we
- ms_fwd_dest  out  5
- ms_fwd_data  out  DATA_W  = ms_final_result
- ms_fwd_stall  out  1  load in MEM with data not yet available; ID must interlock

Behaviour:
- Reset: ms_valid=0, buf_valid=0, cancel_cnt=0. All valid/stall outputs are 0; data outputs are don't-care.
- Accept:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - Fields latch on es_to_ms_valid && ms_allowin.
  - ms_valid <= es_to_ms_valid when ms_allowin.
- Per-instruction state:
  - NOREQ: non-load, or es_req_sent=0.
  - WAIT: load, response not yet seen.
  - HELD: response captured in buffer.
- ms_ready_go = NOREQ || HELD || (WAIT && data_ok && cancel_cnt==0).
- Response routing:
  - data_ok with cancel_cnt>0: decrement cancel_cnt, drop the data. Never delivered, never buffered.
  - data_ok with cancel_cnt==0 in WAIT and !ws_allowin: capture data_rdata into buffer, go to HELD.
  - data_ok with cancel_cnt==0 in WAIT and ws_allowin: pass through combinationally, zero added latency.
- Extraction uses alu_result[1:0] on the raw word (buffer or data_rdata):
  - byte: lane = addr[1:0].
  - half: lane = addr[1] ? [31:16] : [15:0].
  - word: full 32 bits.
  - Extension follows ld_sign.
  - Non-loads output alu_result.
- Flush:
  - ms_valid <= 0, buffer cleared.
  - cancel_cnt <= cancel_cnt + (ms_valid && WAIT && !data_ok_this_cycle) + es_req_pending − (data_ok && cancel_cnt>0).
  - Flush overrides the same-cycle accept.
  - Overflow past MAX_INFLIGHT is a simulation assertion failure; the counter saturates.
- WB stall while HELD: outputs stable, ms_allowin=0.
- ms_fwd_stall = ms_valid && es_ld_en_r && !ms_ready_go.

Optional Feature:
- Macro: MS_MISALIGN_CHECK_EN.
- Defined:
  - Adds output ms_ale (1 bit): ms_valid && load && ((half && addr[0]) || (word && addr[1:0]!=0)).
  - A misaligned load is treated as NOREQ; it proceeds with ms_gr_we forced 0.
  - Port exists only when the macro is defined.
- Undefined:
  - No ms_ale port.
  - Low address bits are ignored for word loads; half uses addr[1] only.

Decomposition:
- Shared package/header mycpu_pkg:
  - LD_SIZE_B/H/W encodings
  - MS_ST_NOREQ/WAIT/HELD state encodings
  - DATA_W constant
- Sub-module load_extract (combinational): raw word, addr[1:0], size, sign → 32-bit result. Reused by future cache-refill paths.

Test Plan:
- ALU op, pc=0x1C000000, result=0x12345678, ws_allowin=1 → ms_to_ws_valid next cycle, ms_final_result=0x12345678, no stall.
- lb signed, addr low bits=2'b11, data_ok after 3 cycles with rdata=0x80FF00AA → ms_fwd_stall=1 for 3 cycles, then result 0xFFFFFF80.
- lhu, addr[1]=1, data_ok while ws_allowin=0 for 4 cycles, rdata=0xBEEF1234 → buffered; stable 0x0000BEEF delivered when ws_allowin rises; ms_allowin=0 meanwhile.
- Flush with MEM in WAIT and es_req_pending=1 → cancel_cnt=2; next two data_ok (0xDEAD, 0xBEEF) dropped; third data_ok delivered to the new load.
- Flush in the same cycle as a cancel-covered data_ok → counter nets correctly (e.g. 1→1 with one new cancel); back-to-back loads then stream at 1/cycle with data_ok each cycle.
- With MS_MISALIGN_CHECK_EN, lw at addr 0x...2 → ms_ale=1, gr_we=0, no response awaited.
